// File: rtl/hazard_unit.sv
// Pipeline hazard unit: combinational stall/flush generation for memory waits,
// taken branches and load-use dependencies, plus a RUN/WAIT tracker that
// counts memory-wait cycles, flags over-long waits and counts front-end stalls.
module hazard_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic        uses_rs1_D,
  input  logic        uses_rs2_D,
  input  logic [4:0]  rd_E,
  input  logic        isLoadE,
  input  logic        regWriteE,
  input  logic        isLoadM,
  input  logic        isStoreM,
  input  logic        mem_ready_M,
  input  logic        branch_taken_E,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        stall_M,
  output logic        flush_D,
  output logic        flush_E,
  output logic        flush_WB,
  output logic        mem_wait,
  output logic [31:0] stall_count,
  output logic        timeout_err
);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        mem_busy;
  logic        rs1_hit, rs2_hit, load_use;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign mem_busy = (isLoadM | isStoreM) & ~mem_ready_M;
  assign rs1_hit  = uses_rs1_D & (rs1_D == rd_E);
  assign rs2_hit  = uses_rs2_D & (rs2_D == rd_E);
  assign load_use = isLoadE & regWriteE & (rd_E != 5'd0) & (rs1_hit | rs2_hit);

  // Stall/flush priority: memory wait freezes everything (a pending branch stays
  // held in Execute and fires once memory completes), then branch, then load-use.
  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    flush_WB = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        stall_E  = 1'b1;
        stall_M  = 1'b1;
        flush_WB = 1'b1;
      end else if (branch_taken_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  // Next state and wait-cycle counter; the counter only runs while waiting.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = 8'd0;
    case (state_reg)
      RUN: begin
        if (mem_busy) state_next = WAIT;
      end
      WAIT: begin
        if (!mem_busy) state_next = RUN;
        wait_cnt_next = (wait_cnt_reg == 8'hFF) ? 8'hFF : wait_cnt_reg + 8'd1;
      end
      default: state_next = RUN;
    endcase
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if ((state_reg == WAIT) && mem_busy && (wait_cnt_next == 8'hFF))
        timeout_err <= 1'b1;
    end
  end

  // Saturating count of cycles with the fetch stage stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= 32'd0;
    else if (stall_F && (stall_count != 32'hFFFF_FFFF))
      stall_count <= stall_count + 32'd1;
  end

  assign mem_wait = (state_reg == WAIT);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: reset, load-use, x0, branch, memory wait,
// simultaneous events, timeout and asynchronous reset mid-wait.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_D, rs2_D, rd_E;
  logic        uses_rs1_D, uses_rs2_D, isLoadE, regWriteE;
  logic        isLoadM, isStoreM, mem_ready_M, branch_taken_E;
  logic        stall_F, stall_D, stall_E, stall_M;
  logic        flush_D, flush_E, flush_WB, mem_wait, timeout_err;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Packed view: {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_WB}
  logic [6:0] vec;
  assign vec = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_WB};

  localparam logic [6:0] V_NONE   = 7'b0000000;
  localparam logic [6:0] V_LOAD   = 7'b1100010;
  localparam logic [6:0] V_BRANCH = 7'b0000110;
  localparam logic [6:0] V_MEM    = 7'b1111001;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .uses_rs1_D(uses_rs1_D), .uses_rs2_D(uses_rs2_D),
    .rd_E(rd_E), .isLoadE(isLoadE), .regWriteE(regWriteE),
    .isLoadM(isLoadM), .isStoreM(isStoreM), .mem_ready_M(mem_ready_M),
    .branch_taken_E(branch_taken_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_WB(flush_WB),
    .mem_wait(mem_wait), .stall_count(stall_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1_D = 5'd0; rs2_D = 5'd0; rd_E = 5'd0;
    uses_rs1_D = 1'b0; uses_rs2_D = 1'b0; isLoadE = 1'b0; regWriteE = 1'b0;
    isLoadM = 1'b0; isStoreM = 1'b0; mem_ready_M = 1'b0; branch_taken_E = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    // Outputs forced quiet during reset even with a pending memory miss.
    isLoadM = 1'b1;
    #2;
    chk("rst_vec", {25'd0, vec}, {25'd0, V_NONE});
    tick();
    chk("rst_cnt", stall_count, 32'd0);
    chk("rst_wait", {31'd0, mem_wait}, 32'd0);
    chk("rst_tout", {31'd0, timeout_err}, 32'd0);
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("idle_vec", {25'd0, vec}, {25'd0, V_NONE});
    tick();
    chk("idle_wait", {31'd0, mem_wait}, 32'd0);

    // Load-use on rs1: one bubble, one stall cycle counted.
    isLoadE = 1'b1; regWriteE = 1'b1; rd_E = 5'd5; rs1_D = 5'd5; uses_rs1_D = 1'b1;
    #1 chk("lu_vec", {25'd0, vec}, {25'd0, V_LOAD});
    tick();
    idle_inputs();   // bubble now in Execute
    #1 chk("lu_bubble", {25'd0, vec}, {25'd0, V_NONE});
    chk("lu_cnt", stall_count, 32'd1);

    // x0 never causes a hazard.
    isLoadE = 1'b1; regWriteE = 1'b1; rd_E = 5'd0; rs1_D = 5'd0; uses_rs1_D = 1'b1;
    #1 chk("x0_vec", {25'd0, vec}, {25'd0, V_NONE});
    tick();
    chk("x0_cnt", stall_count, 32'd1);

    // rs2 match only matters when rs2 is used and the load writes back.
    idle_inputs();
    isLoadE = 1'b1; regWriteE = 1'b1; rd_E = 5'd7; rs1_D = 5'd3; rs2_D = 5'd7;
    uses_rs1_D = 1'b1; uses_rs2_D = 1'b0;
    #1 chk("rs2_unused", {25'd0, vec}, {25'd0, V_NONE});
    uses_rs2_D = 1'b1; regWriteE = 1'b0;
    #1 chk("rs2_nowrite", {25'd0, vec}, {25'd0, V_NONE});
    regWriteE = 1'b1;
    #1 chk("rs2_hit", {25'd0, vec}, {25'd0, V_LOAD});
    tick();
    chk("rs2_cnt", stall_count, 32'd2);

    // Branch beats load-use.
    idle_inputs();
    branch_taken_E = 1'b1;
    #1 chk("br_vec", {25'd0, vec}, {25'd0, V_BRANCH});
    isLoadE = 1'b1; regWriteE = 1'b1; rd_E = 5'd9; rs1_D = 5'd9; uses_rs1_D = 1'b1;
    #1 chk("br_lu_vec", {25'd0, vec}, {25'd0, V_BRANCH});
    tick();
    chk("br_cnt", stall_count, 32'd2);

    // Memory wait: three busy cycles then ready.
    idle_inputs();
    isLoadM = 1'b1; mem_ready_M = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk($sformatf("mw_vec%0d", i), {25'd0, vec}, {25'd0, V_MEM});
      chk($sformatf("mw_wait%0d", i), {31'd0, mem_wait}, (i == 1) ? 32'd0 : 32'd1);
      tick();
    end
    mem_ready_M = 1'b1;
    #1 chk("mw_done_vec", {25'd0, vec}, {25'd0, V_NONE});
    chk("mw_wait4", {31'd0, mem_wait}, 32'd1);
    tick();
    idle_inputs();
    #1 chk("mw_run", {31'd0, mem_wait}, 32'd0);
    chk("mw_cnt", stall_count, 32'd5);

    // Branch and load-use held across a store wait: flush deferred, no stall after.
    isStoreM = 1'b1; mem_ready_M = 1'b0; branch_taken_E = 1'b1;
    isLoadE = 1'b1; regWriteE = 1'b1; rd_E = 5'd12; rs2_D = 5'd12; uses_rs2_D = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      #1 chk($sformatf("sim_vec%0d", i), {25'd0, vec}, {25'd0, V_MEM});
      tick();
    end
    mem_ready_M = 1'b1;
    #1 chk("sim_after", {25'd0, vec}, {25'd0, V_BRANCH});
    tick();
    chk("sim_cnt", stall_count, 32'd7);
    idle_inputs();
    tick();
    chk("sim_run", {31'd0, mem_wait}, 32'd0);

    // Long wait: timeout only after roughly 256 waiting cycles, then sticky.
    isLoadM = 1'b1; mem_ready_M = 1'b0;
    for (int i = 0; i < 200; i++) tick();
    chk("to_early", {31'd0, timeout_err}, 32'd0);
    for (int i = 0; i < 100; i++) tick();
    chk("to_set", {31'd0, timeout_err}, 32'd1);
    chk("to_vec", {25'd0, vec}, {25'd0, V_MEM});
    mem_ready_M = 1'b1;
    tick(); tick();
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    chk("to_run", {31'd0, mem_wait}, 32'd0);

    // Asynchronous reset in the middle of a new wait.
    mem_ready_M = 1'b0;
    tick(); tick(); tick();
    chk("ar_inwait", {31'd0, mem_wait}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_wait", {31'd0, mem_wait}, 32'd0);
    chk("ar_tout", {31'd0, timeout_err}, 32'd0);
    chk("ar_cnt", stall_count, 32'd0);
    chk("ar_vec", {25'd0, vec}, {25'd0, V_NONE});
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();
    chk("ar_after_tout", {31'd0, timeout_err}, 32'd0);
    chk("ar_after_cnt", stall_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 rs1_D, rs2_D  input  5 each  source register indices of instruction in Decode.
REQ-004 uses_rs1_D, uses_rs2_D  input  1 each  Decode instruction reads rs1 / rs2.
REQ-005 rd_E  input  5  destination index in Execute; isLoadE, regWriteE  input  1 each  Execute qualifiers.
REQ-006 isLoadM, isStoreM  input  1 each  memory op in Memory stage; mem_ready_M  input  1  memory completes this cycle.
REQ-007 branch_taken_E  input  1  Execute resolved a taken branch/jump.
REQ-008 stall_F, stall_D, stall_E, stall_M  output  1 each  hold the stage register.
REQ-009 flush_D, flush_E, flush_WB  output  1 each  load a bubble into the stage register.
REQ-010 mem_wait  output  1  registered: FSM is in WAIT.
REQ-011 stall_count  output  32  cycles on which stall_F was asserted, saturating.
REQ-012 timeout_err  output  1  sticky: memory wait exceeded limit.

Function
REQ-013 Terms: mem_busy = (isLoadM | isStoreM) & ~mem_ready_M; load_use = isLoadE & regWriteE & (rd_E != 0) & ((uses_rs1_D & rs1_D == rd_E) | (uses_rs2_D & rs2_D == rd_E)).
REQ-014 Register x0 SHALL never cause a hazard.
REQ-015 All stall/flush outputs SHALL be combinational from current inputs; no added latency.
REQ-016 Priority, highest first: mem_busy, then branch_taken_E, then load_use.
REQ-017 mem_busy: stall_F = stall_D = stall_E = stall_M = 1, flush_WB = 1, flush_D = flush_E = 0, regardless of branch_taken_E or load_use.
REQ-018 The branch flush SHALL be deferred, not lost: branch_taken_E remains held in the stalled Execute stage and SHALL take effect on the first cycle with mem_busy = 0.
REQ-019 branch_taken_E without mem_busy: flush_D = flush_E = 1, all stalls 0, even if load_use = 1.
REQ-020 load_use only: stall_F = stall_D = 1, flush_E = 1, others 0; exactly one bubble per load.
REQ-021 No hazard condition: all stall/flush outputs 0.
REQ-022 FSM states: RUN, WAIT; register reset value is RUN.
REQ-023 RUN -> WAIT when mem_busy = 1 at the clock edge. WAIT -> RUN when mem_busy = 0 at the clock edge. All other cases hold the current state.
REQ-024 mem_wait = 1 only while the FSM is in WAIT.
REQ-025 wait_cnt (8-bit, internal) SHALL clear in RUN and increment each cycle in WAIT.
REQ-026 The cycle on which wait_cnt reaches 255 with mem_busy still 1 SHALL set timeout_err = 1.
REQ-027 timeout_err is sticky until reset; wait_cnt saturates at 255; stalls continue while mem_busy = 1.
REQ-028 stall_count SHALL increment by 1 on every cycle with stall_F = 1 and saturate at 0xFFFF_FFFF.
REQ-029 A load_use that coincides with mem_busy is serviced once mem_busy clears, provided Decode/Execute still hold the same instructions; no bubble is inserted during the wait.

Reset
REQ-030 reset = 1 SHALL immediately force: state RUN, wait_cnt 0, stall_count 0, timeout_err 0, mem_wait 0, independent of clk.
REQ-031 While reset = 1, all stall/flush outputs SHALL be 0.
REQ-032 Reset asserted during WAIT SHALL abandon the wait without raising timeout_err.

Verification
REQ-033 Load-use: isLoadE = 1, regWriteE = 1, rd_E = 5, rs1_D = 5, uses_rs1_D = 1 -> stall_F = stall_D = flush_E = 1 for one cycle; stall_count = 1.
REQ-034 x0 case: same as REQ-033 with rd_E = rs1_D = 0 -> no stall or flush; stall_count unchanged.
REQ-035 Memory wait: isLoadM = 1, mem_ready_M = 0 for 3 cycles, then 1 -> all four stalls and flush_WB high for 3 cycles; mem_wait high for cycles 2-4; then RUN.
REQ-036 Simultaneous events, part 1: branch_taken_E = 1 with mem_busy = 1 for 2 cycles -> flush_D/flush_E stay 0 during the wait.
REQ-037 Simultaneous events, part 2: on the first cycle after the wait -> flush_D = flush_E = 1; with load_use also 1 -> flush only, no stall.
REQ-038 Timeout and reset: mem_busy held 300 cycles -> timeout_err rises at wait_cnt = 255 and stays high; async reset mid-wait -> all state cleared before the next clk edge.
